// File: rtl/mfe_pkg.sv
// Shared types and constants for the mfe_stream median filter engine.
// Border mode follows MFE_REPLICATE_BORDER_EN: defined = replicate edge pixels, undefined = zero padding.
package mfe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAP,
    S_MED,
    S_WRITE
  } state_e;

  localparam int WIN           = 3;
  localparam int RD_PER_COL    = 3;
  localparam int CYC_PER_PIX   = 6;
  localparam int ROW_START_CYC = 9;

`ifdef MFE_REPLICATE_BORDER_EN
  localparam bit BORDER_REPLICATE = 1'b1;
`else
  localparam bit BORDER_REPLICATE = 1'b0;
`endif

  // Load slots 0..2 fetch the first column, 3..5 the second (row start only).
  function automatic logic [1:0] slot_row(input logic [2:0] s);
    return 2'((s >= 3'(RD_PER_COL)) ? s - 3'(RD_PER_COL) : s);
  endfunction

  function automatic logic slot_hi(input logic [2:0] s);
    return s >= 3'(RD_PER_COL);
  endfunction

endpackage

// File: rtl/mfe_median9.sv
// Combinational median of nine unsigned pixels using a 19-stage compare-exchange network.
module mfe_median9 #(
  parameter int PIX_W = 8
) (
  input  logic [8:0][PIX_W-1:0] taps,
  output logic [PIX_W-1:0]      median
);

  localparam int NCX = 19;
  localparam int CX_LO [NCX] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int CX_HI [NCX] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

  logic [PIX_W-1:0] v [9];
  logic [PIX_W-1:0] a, b;

  // NOTE: blocking assignments here model a chain of stages in one cycle;
  // each exchange must see the result of the one before it.
  always_comb begin
    for (int j = 0; j < 9; j++) v[j] = taps[j];
    a = '0;
    b = '0;
    for (int i = 0; i < NCX; i++) begin
      a = v[CX_LO[i]];
      b = v[CX_HI[i]];
      if (a > b) begin
        v[CX_LO[i]] = b;
        v[CX_HI[i]] = a;
      end
    end
    median = v[4];
  end

endmodule

// File: rtl/mfe_stream.sv
// 3x3 median filter over an IMG_W x IMG_H image with column-reuse fetching.
// Border handling is selected by MFE_REPLICATE_BORDER_EN (see mfe_pkg).
module mfe_stream
  import mfe_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [PIX_W-1:0]  idata,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data_wr,
  output logic              wen
);

  // CAP, MED and WRITE follow every load phase.
  localparam int               TAIL_CYC      = 3;
  localparam logic [2:0]       LAST_SLOT_ROW = 3'(ROW_START_CYC - TAIL_CYC - 1);
  localparam logic [2:0]       LAST_SLOT_COL = 3'(CYC_PER_PIX - TAIL_CYC - 1);
  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] x, y, row_base;
  logic [ADDR_W-1:0] row_addr, col;
  logic [2:0]        slot, last_slot, rd_slot;
  logic              rd_valid, last_pix;
  logic [1:0]        cap_r;
  logic              cap_c2, cap_oob;
  logic [PIX_W-1:0]  cap_val, med, med_q;
  logic [PIX_W-1:0]  win [WIN][WIN];
  logic [8:0][PIX_W-1:0] taps;

  assign last_slot = (x == '0) ? LAST_SLOT_ROW : LAST_SLOT_COL;
  assign last_pix  = (x == X_LAST) && (y == Y_LAST);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (ready) state_nx = S_LOAD;
      S_LOAD:  if (slot == last_slot) state_nx = S_CAP;
      S_CAP:   state_nx = S_MED;
      S_MED:   state_nx = S_WRITE;
      S_WRITE: state_nx = last_pix ? S_IDLE : S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      slot     <= '0;
      rd_valid <= 1'b0;
      rd_slot  <= '0;
      med_q    <= '0;
    end else begin
      state    <= state_nx;
      rd_valid <= (state == S_LOAD);
      rd_slot  <= slot;
      if (state == S_LOAD) slot <= (slot == last_slot) ? 3'd0 : slot + 3'd1;
      if (state == S_MED) med_q <= med;
      if (state == S_IDLE && ready) begin
        x        <= '0;
        y        <= '0;
        row_base <= '0;
      end
      if (state == S_WRITE && !last_pix) begin
        if (x == X_LAST) begin
          x        <= '0;
          y        <= y + ONE;
          row_base <= row_base + ROW_STEP;
        end else begin
          x <= x + ONE;
        end
      end
    end
  end

  // Fetch address: rows clamp at the top/bottom edge, the right column clamps at IMG_W-1.
  always_comb begin
    row_addr = row_base;
    col      = '0;
    iaddr    = '0;
    case (slot_row(slot))
      2'd0:    if (y != '0) row_addr = row_base - ROW_STEP;
      2'd2:    if (y != Y_LAST) row_addr = row_base + ROW_STEP;
      default: row_addr = row_base;
    endcase
    if (x == '0)          col = slot_hi(slot) ? ONE : '0;
    else if (x != X_LAST) col = x + ONE;
    else                  col = X_LAST;
    if (state == S_LOAD) iaddr = row_addr + col;
  end

  // The returning read lands one cycle after its slot; out-of-range taps become 0 in zero mode.
  always_comb begin
    cap_r   = slot_row(rd_slot);
    cap_c2  = (x != '0) || slot_hi(rd_slot);
    cap_oob = ((cap_r == 2'd0) && (y == '0)) ||
              ((cap_r == 2'd2) && (y == Y_LAST)) ||
              (cap_c2 && (x == X_LAST));
    cap_val = (cap_oob && !BORDER_REPLICATE) ? '0 : idata;
  end

  // NOTE: the window is only nine registers, so it is reset like any other state
  // (a large RAM-backed buffer would be left unreset).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) win[r][c] <= '0;
    end else begin
      if (state == S_LOAD && slot == 3'd0) begin
        for (int r = 0; r < WIN; r++) begin
          if (x == '0) begin
            win[r][0] <= '0;
          end else begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
          end
        end
      end
      if (rd_valid) begin
        if (cap_c2) begin
          win[cap_r][2] <= cap_val;
        end else begin
          win[cap_r][1] <= cap_val;
          if (BORDER_REPLICATE) win[cap_r][0] <= cap_val;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) taps[r*WIN+c] = win[r][c];
  end

  mfe_median9 #(.PIX_W(PIX_W)) u_median (
    .taps   (taps),
    .median (med)
  );

  assign busy    = (state != S_IDLE);
  assign wen     = (state == S_WRITE);
  assign addr    = row_base + x;
  assign data_wr = med_q;

endmodule

// File: tb/tb_mfe_stream.sv
// Self-checking bench for mfe_stream on a 5x4 image against a behavioural median model.
module tb_mfe_stream;

  localparam int W       = 5;
  localparam int H       = 4;
  localparam int PW      = 8;
  localparam int AW      = $clog2(W * H);
  localparam int N       = W * H;
  localparam int RUN_CYC = H * (6 * W + 3);
`ifdef MFE_REPLICATE_BORDER_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ready = 1'b0;
  logic          busy, wen;
  logic [AW-1:0] iaddr, addr;
  logic [PW-1:0] idata, data_wr;

  int passed = 0;
  int total  = 0;
  logic [PW-1:0] img [N];
  int wr_addr_q [$];
  int wr_data_q [$];
  int wen_in_reset = 0;

  mfe_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .busy    (busy),
    .iaddr   (iaddr),
    .idata   (idata),
    .addr    (addr),
    .data_wr (data_wr),
    .wen     (wen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) idata <= img[iaddr];

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wr_addr_q.push_back(int'(addr));
      wr_data_q.push_back(int'(data_wr));
      if (reset !== 1'b1) wen_in_reset++;
    end
  end

  // Reference: gather the 3x3 neighbourhood by the border rule, sort, take the middle.
  function automatic int model_pix(int x, int y);
    int v [9];
    int k, xx, yy, t;
    bit inb;
    k = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx  = x + dx;
        yy  = y + dy;
        inb = (xx >= 0) && (xx < W) && (yy >= 0) && (yy < H);
        xx  = (xx < 0) ? 0 : (xx >= W) ? W - 1 : xx;
        yy  = (yy < 0) ? 0 : (yy >= H) ? H - 1 : yy;
        v[k] = (inb || REPL) ? int'(img[yy*W+xx]) : 0;
        k++;
      end
    end
    for (int i = 1; i < 9; i++) begin
      t = v[i];
      for (int j = i; j > 0; j--) begin
        if (v[j-1] > t) begin
          v[j] = v[j-1];
          v[j-1] = t;
        end
      end
    end
    return v[4];
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 4 * RUN_CYC) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_cycles(string tag, int cyc);
    total++;
    if (cyc !== RUN_CYC) $display("FAIL %s cycles: got %0d need %0d", tag, cyc, RUN_CYC);
    else passed++;
  endtask

  task automatic check_image(string tag, int base);
    bit ok;
    int bad;
    int exp;
    total++;
    if (wr_addr_q.size() < base + N) begin
      $display("FAIL %s write count: got %0d need %0d", tag, wr_addr_q.size() - base, N);
      return;
    end
    passed++;
    ok  = 1'b1;
    bad = -1;
    for (int i = 0; i < N; i++) begin
      if (ok && wr_addr_q[base+i] != i) begin
        ok  = 1'b0;
        bad = i;
      end
    end
    total++;
    if (!ok) $display("FAIL %s addr order: write %0d got addr %0d need %0d", tag, bad, wr_addr_q[base+bad], bad);
    else passed++;
    for (int i = 0; i < N; i++) begin
      exp = model_pix(i % W, i / W);
      total++;
      if (wr_data_q[base+i] !== exp)
        $display("FAIL %s pixel (%0d,%0d): got %0d need %0d", tag, i % W, i / W, wr_data_q[base+i], exp);
      else passed++;
    end
  endtask

  task automatic run_image(string tag);
    int cyc;
    clear_log();
    start_pulse();
    wait_idle(cyc);
    check_cycles(tag, cyc);
    total++;
    if (wr_addr_q.size() !== N) $display("FAIL %s exact writes: got %0d need %0d", tag, wr_addr_q.size(), N);
    else passed++;
    check_image(tag, 0);
  endtask

  task automatic test_reset();
    #2;
    total += 5;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b need 0", busy); else passed++;
    if (wen !== 1'b0) $display("FAIL reset wen: got %b need 0", wen); else passed++;
    if (iaddr !== '0) $display("FAIL reset iaddr: got %0d need 0", iaddr); else passed++;
    if (addr !== '0) $display("FAIL reset addr: got %0d need 0", addr); else passed++;
    if (data_wr !== '0) $display("FAIL reset data_wr: got %0d need 0", data_wr); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_flat();
    for (int i = 0; i < N; i++) img[i] = 8'd200;
    run_image("flat");
    if (wr_data_q.size() >= N) begin
      total += 2;
      if (wr_data_q[0] !== (REPL ? 200 : 0))
        $display("FAIL flat corner: got %0d need %0d", wr_data_q[0], REPL ? 200 : 0);
      else passed++;
      if (wr_data_q[1] !== 200) $display("FAIL flat top edge: got %0d need 200", wr_data_q[1]);
      else passed++;
    end
  endtask

  task automatic test_impulse();
    int nz;
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[2*W+2] = 8'd255;
    run_image("impulse");
    nz = 0;
    foreach (wr_data_q[i]) if (wr_data_q[i] != 0) nz++;
    total++;
    if (nz !== 0) $display("FAIL impulse nonzero outputs: got %0d need 0", nz);
    else passed++;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) img[i] = PW'(i + 1);
    run_image("ramp");
    if (wr_data_q.size() > W + 1) begin
      total++;
      if (wr_data_q[W+1] !== 7) $display("FAIL ramp (1,1): got %0d need 7", wr_data_q[W+1]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < N; i++) img[i] = (n < 2) ? PW'($urandom) : PW'($urandom_range(0, 3));
      run_image("random");
    end
  endtask

  task automatic test_reset_mid();
    int seen, guard;
    for (int i = 0; i < N; i++) img[i] = PW'($urandom);
    clear_log();
    start_pulse();
    seen  = 0;
    guard = 0;
    while (seen < 8 && guard < 2 * RUN_CYC) begin
      @(negedge clk);
      guard++;
      if (wen === 1'b1) seen++;
    end
    total++;
    if (seen !== 8) $display("FAIL reset_mid reach write 8: got %0d need 8", seen);
    else passed++;
    #1 reset = 1'b0;
    #1;
    total += 5;
    if (wen !== 1'b0) $display("FAIL reset_mid wen: got %b need 0", wen); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_mid busy: got %b need 0", busy); else passed++;
    if (iaddr !== '0) $display("FAIL reset_mid iaddr: got %0d need 0", iaddr); else passed++;
    if (addr !== '0) $display("FAIL reset_mid addr: got %0d need 0", addr); else passed++;
    if (data_wr !== '0) $display("FAIL reset_mid data_wr: got %0d need 0", data_wr); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (wen_in_reset !== 0) $display("FAIL reset_mid writes in reset: got %0d need 0", wen_in_reset);
    else passed++;
    reset = 1'b1;
    run_image("after_reset");
  endtask

  task automatic test_back_to_back();
    int c1, c2, idle;
    for (int i = 0; i < N; i++) img[i] = PW'($urandom);
    clear_log();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    wait_idle(c1);
    idle = 0;
    while (busy !== 1'b1 && idle < 10) begin
      idle++;
      @(negedge clk);
    end
    ready = 1'b0;
    wait_idle(c2);
    check_cycles("b2b run1", c1);
    check_cycles("b2b run2", c2);
    total++;
    if (idle !== 1) $display("FAIL b2b idle gap: got %0d need 1", idle);
    else passed++;
    total++;
    if (wr_addr_q.size() !== 2 * N) $display("FAIL b2b writes: got %0d need %0d", wr_addr_q.size(), 2 * N);
    else passed++;
    check_image("b2b run1", 0);
    check_image("b2b run2", N);
  endtask

  initial begin
    for (int i = 0; i < N; i++) img[i] = '0;
    test_reset();
    test_flat();
    test_impulse();
    test_ramp();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mfe_stream.md
# mfe_stream

Parametrised successor to the fixed 128×128 median filter engine. It runs a 3×3 median filter over an IMG_W×IMG_H image of PIX_W-bit pixels, fetched through the existing image port (iaddr/idata). Results go out through the existing result-memory write port (addr/data_wr/wen). It adds a sliding-window column-reuse fetch schedule, so it reads 3 pixels per output instead of 9, and a compile-time border mode.

## Interface
- IMG_W, 128, image width in pixels; must be ≥3.
- IMG_H, 128, image height in pixels; must be ≥3.
- PIX_W, 8, pixel width in bits, unsigned.
- ADDR_W, $clog2(IMG_W*IMG_H), address width, derived.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  start request; sampled only in IDLE.
- busy  out  1  high from the cycle after start until the last write completes.
- iaddr  out  ADDR_W  image read address, row-major (y*IMG_W+x).
- idata  in  PIX_W  image data; valid one cycle after its iaddr.
- addr  out  ADDR_W  result write address, row-major.
- data_wr  out  PIX_W  result pixel.
- wen  out  1  write strobe; 1 = write in this cycle.

## Operation
- States: IDLE, LOAD, CAP, MED, WRITE. Output order is raster order.
- Reset values: busy=0, iaddr=0, addr=0, data_wr=0, wen=0. State=IDLE. Window registers are cleared.
- IDLE with ready=1: go to LOAD, busy=1, and set (x,y)=(0,0). ready is ignored while busy=1.
- Window: 3×3 registers W[r][c]. r=0..2 is rows y-1..y+1. c=0..2 is columns x-1..x+1.
- LOAD at x=0:
  - Clear column c=0 to the border value.
  - Issue 6 reads: column 0 (rows y-1..y+1) into c=1, then column 1 into c=2.
- LOAD at x>0:
  - Shift the window left one column.
  - Issue 3 reads of column x+1 into c=2.
- Out-of-range coordinates (row -1, row IMG_H, column IMG_W) are clamped to the nearest in-range pixel. The clamped address is still issued, so slot timing is fixed.
- Border value: the clamped pixel (replicate) or 0, as set in Configuration.
- CAP: one cycle that captures the last outstanding read.
- MED: registers the median of the 9 unsigned values, computed by mfe_median9.
- WRITE: wen=1, addr=y*IMG_W+x, data_wr=median.
  - If more pixels remain, advance x; at x=IMG_W-1, wrap to x=0 and y+1. Go to LOAD.
  - After the last pixel (IMG_W-1, IMG_H-1), go to IDLE.
- Addresses use an incremental row base (add IMG_W). There are no multipliers.

## Timing
- Read latency: iaddr driven in cycle n → idata captured at the rising edge ending cycle n+1. Reads are pipelined, one per cycle.
- Cycles per output: 6 normally (3 LOAD + CAP + MED + WRITE); 9 at x=0.
- Total from the first busy=1 cycle to the last wen cycle, inclusive: IMG_H*(6*IMG_W+3). For 128×128 this is 98688 cycles.
- busy goes 0 in the cycle after the last WRITE. ready=1 in that IDLE cycle starts a new run immediately.
- wen is high for exactly one cycle per output pixel. addr is strictly increasing within a run.
- Reset asserted mid-run: all outputs return to reset values immediately. The partial image is abandoned. No write occurs while reset is low.

## Configuration
- MFE_REPLICATE_BORDER_EN:
  - Defined: border pixels use the replicated nearest edge pixel.
  - Undefined: out-of-range taps are 0 (zero padding, compatible with the existing golden files).
- Cycle timing and the address sequence are identical in both modes.

## Structure
- mfe_pkg holds:
  - the state enum;
  - PIX_W-independent localparams (window size 3, reads per column 3, cycles per pixel 6, row-start cycles 9);
  - the border-mode constant derived from the macro.
- Sub-module mfe_median9 is a combinational 9-input median built as a compare-exchange network (19 comparators), parametrised on PIX_W. It is instantiated once.

## Test plan
- 128×128 image and golden file, zero mode, compared against the existing golden data: all 16384 pixels match, and the total cycle count is 98688.
- 4×4 image, all pixels 200:
  - Zero mode: corner outputs are 0; edge and interior outputs are 200.
  - Replicate mode: all 16 outputs are 200.
- 5×5 image, all zeros except pixel (2,2)=255: every output is 0, so the impulse is suppressed.
- 3×3 image with pixels 1..9 in raster order: output (1,1)=5. The write addresses are 0..8 in order.
- Reset pulled low during output pixel 50 of a 128×128 run: wen and busy drop immediately. A fresh ready then produces a complete, correct image starting at addr 0.
- Two back-to-back runs with ready held high: busy is low for exactly one cycle between runs, and both images are correct.
